// File: rtl/pixel_line_fifo.sv
// Show-ahead pixel line FIFO between the pixel DMA and the display timing generator.
// Define PIXEL_FIFO_UFLOW_CNT_EN to add the saturating underrun counter port uflow_cnt.
module pixel_line_fifo #(
    parameter int unsigned DEPTH       = 2048,
    parameter int unsigned BURST_LEN   = 256,
    parameter logic [31:0] UFLOW_PIXEL = 32'h0000_0000
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        rd_fifo_en,
    output logic [31:0] rgb_pixel,
    output logic        empty,
    output logic [12:0] level,
    output logic        burst_req,
    output logic        underflow
`ifdef PIXEL_FIFO_UFLOW_CNT_EN
    ,
    output logic [15:0] uflow_cnt
`endif
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [12:0] DEPTH_L  = 13'(DEPTH);
    localparam logic [12:0] BURST_TH = 13'(DEPTH - BURST_LEN);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          s_ready_q;
    logic          burst_q;
    logic          uflow_q;
    logic [12:0]   level_q;
    logic [12:0]   level_nxt;
    logic [12:0]   mem_words;
    logic          wr_acc;
    logic          pop;
    logic          underrun;
    logic          load;
    logic          mem_we;

    // Handshake: a word transfers on every edge with s_valid && s_ready; s_ready is a
    // register, so the DMA may hold s_valid high without any combinational loop back.
    always_comb begin
        wr_acc    = s_valid & s_ready_q;
        pop       = rd_fifo_en & out_valid;
        underrun  = rd_fifo_en & ~out_valid;
        mem_we    = wr_acc & ~frame_start & ~rst;
        mem_words = level_q - 13'(out_valid);
        // Refill the output stage when it is empty or being drained this edge.
        load      = (mem_words != 13'd0) & (~out_valid | pop);
        level_nxt = level_q + 13'(wr_acc) - 13'(pop);
    end

    always_ff @(posedge sclk) begin
        if (mem_we) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            level_q   <= '0;
            s_ready_q <= 1'b0;
            burst_q   <= 1'b0;
            uflow_q   <= 1'b0;
        end else if (frame_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            level_q   <= '0;
            s_ready_q <= 1'b0;
            burst_q   <= 1'b1;
            uflow_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            // The read address never equals a live write address: memory holds at most DEPTH-1 words.
            if (load) begin
                out_data  <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            level_q   <= level_nxt;
            s_ready_q <= (level_nxt != DEPTH_L);
            burst_q   <= (level_nxt <= BURST_TH);
            if (underrun) begin
                uflow_q <= 1'b1;
            end
        end
    end

`ifdef PIXEL_FIFO_UFLOW_CNT_EN
    logic [15:0] uflow_cnt_q;

    always_ff @(posedge sclk) begin
        if (rst || frame_start) begin
            uflow_cnt_q <= '0;
        end else if (underrun && (uflow_cnt_q != 16'hFFFF)) begin
            uflow_cnt_q <= uflow_cnt_q + 16'd1;
        end
    end

    assign uflow_cnt = uflow_cnt_q;
`endif

    // An empty head shows the underrun marker only while the consumer is actually asking.
    assign rgb_pixel = out_valid ? out_data : (rd_fifo_en ? UFLOW_PIXEL : 32'd0);
    assign empty     = ~out_valid;
    assign level     = level_q;
    assign s_ready   = s_ready_q;
    assign burst_req = burst_q;
    assign underflow = uflow_q;

endmodule
